// File: rtl/gpr_wb_queue.sv
// Write-back queue in front of the GPR file: buffers results in FIFO order, drains one
// per cycle into the single write port, and forwards the newest queued value to decode.
module gpr_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [4:0]    enq_addr,
  input  logic [31:0]   enq_data,
  input  logic [31:0]   enq_pc,
  input  logic          drain_en,
  output logic          RFWr,
  output logic [4:0]    A3,
  output logic [31:0]   WD,
  output logic [31:0]   PC,
  input  logic [4:0]    q_a1,
  input  logic [4:0]    q_a2,
  output logic          q_hit1,
  output logic          q_hit2,
  output logic [31:0]   q_data1,
  output logic [31:0]   q_data2,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic not_empty, do_store, do_drain;

  assign not_empty = (count_q != '0);
  assign enq_ready = (count_q < CW'(DEPTH));
  // Writes to r0 complete the handshake but are dropped here, never stored.
  assign do_store  = enq_valid && enq_ready && (enq_addr != 5'd0);
  assign do_drain  = drain_en && not_empty;

  assign RFWr  = do_drain;
  assign A3    = not_empty ? addr_q[head_q] : 5'd0;
  assign WD    = not_empty ? data_q[head_q] : 32'd0;
  assign PC    = not_empty ? pc_q[head_q]   : 32'd0;
  assign count = count_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_drain) head_d = head_q + 1'b1;
    if (do_store) tail_d = tail_q + 1'b1;
    case ({do_store, do_drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is not reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (do_store && !reset) begin
      addr_q[tail_q] <= enq_addr;
      data_q[tail_q] <= enq_data;
      pc_q[tail_q]   <= enq_pc;
    end
  end

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = 32'd0;
    q_data2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (q_a1 != 5'd0 && addr_q[head_q + PW'(i)] == q_a1) begin
          q_hit1  = 1'b1;
          q_data1 = data_q[head_q + PW'(i)];
        end
        if (q_a2 != 5'd0 && addr_q[head_q + PW'(i)] == q_a2) begin
          q_hit2  = 1'b1;
          q_data2 = data_q[head_q + PW'(i)];
        end
      end
    end
  end

endmodule
